// File: rtl/fifo_arb_pkg.sv
// Shared arbitration helpers: round-robin pick function and default burst length.
package fifo_arb_pkg;

  localparam int unsigned DEFAULT_MAX_BURST = 4;
  localparam int unsigned RR_MAX_REQ        = 32;
  localparam int unsigned RR_IDX_W          = 5;

  // Returns {found, index}: first set bit of valid at or after ptr, wrapping at num_req.
  function automatic logic [RR_IDX_W:0] rr_pick(
    input logic [RR_MAX_REQ-1:0] valid,
    input int unsigned           num_req,
    input int unsigned           ptr
  );
    logic [RR_IDX_W:0] res;
    int unsigned       idx;
    res = '0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      if (k < num_req) begin
        idx = ptr + k;
        if (idx >= num_req) idx = idx - num_req;
        if (!res[RR_IDX_W] && valid[idx[RR_IDX_W-1:0]]) begin
          res = {1'b1, idx[RR_IDX_W-1:0]};
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_sel.sv
// Combinational rotate-and-find-first selector with one-hot and index outputs.
module rr_priority_sel
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [RR_MAX_REQ-1:0] valid_ext;
  logic [RR_IDX_W:0]     pick;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid;
    pick                   = rr_pick(valid_ext, NUM_REQ, 32'(ptr));
    found                  = pick[RR_IDX_W];
    idx                    = IDX_W'(pick[RR_IDX_W-1:0]);
    onehot                 = '0;
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers; 1-cycle latency.
// Beat held in the output register while fifo_full; optional per-grant bursts under FIFO_ARB_BURST_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned MAX_BURST = DEFAULT_MAX_BURST,
  localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fifo_wr_en,
  output logic [ID_WIDTH+WIDTH-1:0]   fifo_din,
  input  logic                        fifo_full,
  output logic [ID_WIDTH-1:0]         grant_id
);

  localparam int unsigned OUT_W = ID_WIDTH + WIDTH;

  if (NUM_REQ < 2)   $error("NUM_REQ must be at least 2");
  if (MAX_BURST < 1) $error("MAX_BURST must be at least 1");

  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] last_id_q, last_id_d;

  logic                can_accept;
  logic                found;
  logic                xfer;
  logic [ID_WIDTH-1:0] win_idx;
  logic [ID_WIDTH-1:0] next_idx;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [WIDTH-1:0]    req_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  rr_priority_sel #(.NUM_REQ(NUM_REQ)) u_sel (
    .valid  (req_valid),
    .ptr    (rr_ptr_q),
    .found  (found),
    .idx    (win_idx),
    .onehot (win_onehot)
  );

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] burst_base;
`endif

  always_comb begin
    can_accept  = !out_valid_q || !fifo_full;
    xfer        = found && can_accept;
    req_ready   = xfer ? win_onehot : '0;
    fifo_wr_en  = out_valid_q && !fifo_full;
    fifo_din    = out_data_q;
    grant_id    = found ? win_idx : last_id_q;
    next_idx    = (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    last_id_d   = grant_id;

    // A write and a new capture in the same cycle keep the register full.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = {win_idx, req_arr[win_idx]};
    end else if (fifo_wr_en) begin
      out_valid_d = 1'b0;
    end

`ifdef FIFO_ARB_BURST_EN
    // The run length restarts whenever a different requester wins.
    burst_base  = (!found || win_idx == last_id_q) ? burst_cnt_q : '0;
    burst_cnt_d = burst_base;
    if (xfer) begin
      if (burst_base == CNT_W'(MAX_BURST - 1)) begin
        rr_ptr_d    = next_idx;
        burst_cnt_d = '0;
      end else begin
        rr_ptr_d    = win_idx;
        burst_cnt_d = burst_base + 1'b1;
      end
    end
`else
    if (xfer) rr_ptr_d = next_idx;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
      last_id_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      last_id_q   <= last_id_d;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_cnt_q <= '0;
    else        burst_cnt_q <= burst_cnt_d;
  end
`endif

endmodule
